// File: rtl/sid_bus_sched.sv
// SID bus scheduler: one SID access per 1 MHz phi2 slot, arbitrating a register-clear
// sequencer, a single pending read and a 4-entry write FIFO. Read support under SID_READ_EN.
`timescale 1ns/1ps
module sid_bus_sched (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       clr_req,
  output logic       busy,
  output logic       wr_full,
  output logic       ovf,
  output logic       sid_clk,
  output logic [4:0] sid_a,
  output logic [7:0] sid_do,
  input  logic [7:0] sid_di,
  output logic       sid_oe,
  output logic       sid_cs,
  output logic       sid_wr
);

  typedef enum logic {SEQ_IDLE, SEQ_CLEAR} seq_t;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_WRITE, SLOT_READ, SLOT_CLEAR} slot_t;

  localparam logic [4:0] CLR_END = 5'd25;

  seq_t        state, state_nxt;
  slot_t       slot_q, slot_sel;
  logic [4:0]  cnt;
  logic [4:0]  clr_idx;
  logic        slot_start, slot_end;
  logic        clr_start, clr_done;

  logic [12:0] fifo_mem [4];
  logic [1:0]  wptr, rptr;
  logic [2:0]  occ;
  logic        fifo_empty, push, pop;

  logic        read_ready;
  logic [4:0]  rd_addr_q;

  assign slot_start = (cnt == 5'd7);
  assign slot_end   = (cnt == 5'd31);
  assign sid_clk    = cnt[4];
  assign busy       = (state == SEQ_CLEAR);
  assign fifo_empty = (occ == 3'd0);
  assign wr_full    = (occ == 3'd4);
  assign push       = wr_req && !wr_full;
  assign pop        = slot_start && (slot_sel == SLOT_WRITE);

  // clr_idx has already advanced to 25 when the slot writing register 24 ends
  always_comb begin
    state_nxt = state;
    slot_sel  = SLOT_IDLE;
    clr_start = (state == SEQ_IDLE) && clr_req;
    clr_done  = (state == SEQ_CLEAR) && slot_end && (slot_q == SLOT_CLEAR) &&
                (clr_idx == CLR_END);
    if (clr_start) begin
      state_nxt = SEQ_CLEAR;
    end else if (clr_done) begin
      state_nxt = SEQ_IDLE;
    end
    if (slot_start) begin
      if ((state == SEQ_CLEAR) && (clr_idx != CLR_END)) begin
        slot_sel = SLOT_CLEAR;
      end else if (read_ready) begin
        slot_sel = SLOT_READ;
      end else if (!fifo_empty) begin
        slot_sel = SLOT_WRITE;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      state <= SEQ_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      cnt      <= '0;
      slot_q   <= SLOT_IDLE;
      clr_idx  <= '0;
      sid_cs   <= 1'b1;
      sid_wr   <= 1'b1;
      sid_oe   <= 1'b0;
      sid_a    <= '0;
      sid_do   <= '0;
      rd_data  <= '1;
      rd_valid <= 1'b0;
    end else begin
      cnt      <= cnt + 5'd1;
      rd_valid <= 1'b0;
      if (clr_start) begin
        clr_idx <= '0;
      end
      if (slot_start && (slot_sel != SLOT_IDLE)) begin
        slot_q <= slot_sel;
        sid_cs <= 1'b0;
        sid_wr <= (slot_sel == SLOT_READ);
        sid_oe <= (slot_sel != SLOT_READ);
        case (slot_sel)
          SLOT_CLEAR: begin
            sid_a   <= clr_idx;
            sid_do  <= '0;
            clr_idx <= clr_idx + 5'd1;
          end
          SLOT_WRITE: {sid_a, sid_do} <= fifo_mem[rptr];
          SLOT_READ: begin
            sid_a  <= rd_addr_q;
            sid_do <= '0;
          end
          default: ;
        endcase
      end
      if (slot_end) begin
        sid_cs <= 1'b1;
        sid_wr <= 1'b1;
        sid_oe <= 1'b0;
        slot_q <= SLOT_IDLE;
`ifdef SID_READ_EN
        if (slot_q == SLOT_READ) begin
          rd_data  <= sid_di;
          rd_valid <= 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (push) begin
      fifo_mem[wptr] <= {wr_addr, wr_data};
    end
  end

  // A clear start flushes the FIFO and wins over a same-cycle push or pop
  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      ovf  <= 1'b0;
    end else if (clr_start) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      occ <= occ + {2'b00, push} - {2'b00, pop};
      if (wr_req && wr_full) ovf <= 1'b1;
    end
  end

`ifdef SID_READ_EN
  logic rd_pend;

  assign read_ready = rd_pend;

  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      if (rd_req && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= rd_addr;
      end
      if (slot_start && (slot_sel == SLOT_READ)) begin
        rd_pend <= 1'b0;
      end
    end
  end
`else
  logic unused_rd;

  assign read_ready = 1'b0;
  assign rd_addr_q  = '0;
  assign unused_rd  = ^{rd_req, rd_addr, sid_di};
`endif

endmodule

// File: tb/tb_sid_bus_sched.sv
// Scoreboard bench for sid_bus_sched: expected SID slots and read results are queued when
// stimulus is driven and checked as the bus monitor observes them.
`timescale 1ns/1ps
module tb_sid_bus_sched;

  logic       clk32, rst_n;
  logic       wr_req, rd_req, clr_req;
  logic [4:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data, sid_do, sid_di;
  logic       rd_valid, busy, wr_full, ovf;
  logic       sid_clk, sid_oe, sid_cs, sid_wr;
  logic [4:0] sid_a;

  sid_bus_sched dut (
    .clk32(clk32), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy), .wr_full(wr_full), .ovf(ovf),
    .sid_clk(sid_clk), .sid_a(sid_a), .sid_do(sid_do), .sid_di(sid_di),
    .sid_oe(sid_oe), .sid_cs(sid_cs), .sid_wr(sid_wr)
  );

  typedef struct packed {
    logic       rd;
    logic [4:0] a;
    logic [7:0] d;
  } slot_exp_t;

  slot_exp_t   sq[$];
  logic [7:0]  rq[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus monitor
  slot_exp_t   mon_e;
  logic        in_slot = 1'b0, slot_ok, prev_rdv = 1'b0;
  logic        rec_wr, rec_oe;
  logic [4:0]  rec_a;
  logic [7:0]  rec_d;
  int unsigned len, rdv_seen = 0;

  always @(negedge clk32) begin
    if (!rst_n) begin
      in_slot  = 1'b0;
      prev_rdv = 1'b0;
    end else begin
      if (!sid_cs) begin
        if (!in_slot) begin
          in_slot = 1'b1;
          len     = 1;
          slot_ok = 1'b1;
          rec_a = sid_a; rec_d = sid_do; rec_wr = sid_wr; rec_oe = sid_oe;
          check("slot_phase", sid_clk, 0);
          check("slot_expected", sq.size() != 0, 1);
          if (sq.size() != 0) begin
            mon_e = sq.pop_front();
            check("slot_wr_n", sid_wr, mon_e.rd);
            check("slot_oe", sid_oe, !mon_e.rd);
            check("slot_a", sid_a, mon_e.a);
            if (!mon_e.rd) check("slot_do", sid_do, mon_e.d);
          end
        end else begin
          len++;
          if (sid_a !== rec_a || sid_do !== rec_d || sid_wr !== rec_wr || sid_oe !== rec_oe)
            slot_ok = 1'b0;
        end
      end else if (in_slot) begin
        in_slot = 1'b0;
        check("slot_len", len, 24);
        check("slot_stable", slot_ok, 1);
        check("slot_release", {sid_wr, sid_oe}, 2'b10);
      end
      if (rd_valid) begin
        rdv_seen++;
        check("rdv_single", prev_rdv, 0);
        if (!prev_rdv) begin
          check("rd_expected", rq.size() != 0, 1);
          if (rq.size() != 0) check("rd_data", rd_data, rq.pop_front());
        end
      end
      prev_rdv = rd_valid;
    end
  end

  task automatic push_clear();
    for (int unsigned i = 0; i < 25; i++) sq.push_back('{rd: 1'b0, a: i[4:0], d: 8'h00});
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    sq.push_back('{rd: 1'b0, a: a, d: d});
  endtask

  // Returns on the negedge where cnt has just become 16
  task automatic sync16();
    logic p;
    bit   hit = 0;
    p = sid_clk;
    for (int unsigned n = 0; n < 80 && !hit; n++) begin
      @(negedge clk32);
      hit = sid_clk && !p;
      p   = sid_clk;
    end
    check("sync_timeout", hit, 1);
  endtask

  task automatic wait_idle(input int unsigned budget);
    bit done = 0;
    for (int unsigned n = 0; n < budget && !done; n++) begin
      @(negedge clk32);
      done = (sq.size() == 0) && (rq.size() == 0) && sid_cs && !busy;
    end
    check("idle_timeout", done, 1);
  endtask

  task automatic release_and_time(input bit poke_clr);
    int unsigned n = 0;
    bit fell = 0;
    rst_n = 1'b1;
    while (!fell && n < 2000) begin
      @(posedge clk32);
      #1;
      n++;
      if (poke_clr) clr_req = (n == 100);
      fell = !busy;
    end
    clr_req = 1'b0;
    check("clear_duration", n, 800);
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; sid_di = 8'hA5;
    repeat (3) @(negedge clk32);
    check("rst_cs", sid_cs, 1);
    check("rst_wr", sid_wr, 1);
    check("rst_oe", sid_oe, 0);
    check("rst_a", sid_a, 0);
    check("rst_do", sid_do, 0);
    check("rst_rd_data", rd_data, 8'hFF);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_full", wr_full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 1);
    check("rst_sid_clk", sid_clk, 0);

    // Automatic clear after reset release
    push_clear();
    release_and_time(1'b0);
    check("clr_all_issued", sq.size(), 0);

    // Single write
    @(negedge clk32);
    wr_req = 1'b1; wr_addr = 5'h18; wr_data = 8'h0F;
    push_wr(5'h18, 8'h0F);
    @(negedge clk32);
    wr_req = 1'b0;
    wait_idle(200);

    // Five back-to-back writes well away from the selection point
    sync16();
    for (int unsigned i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = 5'd5 + i[4:0]; wr_data = 8'h30 + i[7:0];
      if (i < 4) push_wr(5'd5 + i[4:0], 8'h30 + i[7:0]);
      @(negedge clk32);
      if (i == 2) check("full_at3", wr_full, 0);
      if (i == 3) begin
        check("full_at4", wr_full, 1);
        check("ovf_at4", ovf, 0);
      end
    end
    wr_req = 1'b0;
    check("ovf_drop", ovf, 1);
    wait_idle(300);
    check("full_drained", wr_full, 0);
    check("ovf_sticky", ovf, 1);

    // Read and write pending together
    sync16();
    wr_req = 1'b1; wr_addr = 5'h03; wr_data = 8'h55;
    rd_req = 1'b1; rd_addr = 5'h1B;
`ifdef SID_READ_EN
    sq.push_back('{rd: 1'b1, a: 5'h1B, d: 8'h00});
    rq.push_back(8'hA5);
`endif
    push_wr(5'h03, 8'h55);
    @(negedge clk32);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_idle(300);
`ifdef SID_READ_EN
    check("rdv_count", rdv_seen, 1);
`else
    check("rdv_none", rdv_seen, 0);
    check("rd_data_idle", rd_data, 8'hFF);
`endif

    // clr_req while idle: flush queued writes and ovf, later pushes issue after the clear
    push_clear();
    sync16();
    wr_req = 1'b1; wr_addr = 5'h01; wr_data = 8'hAA;
    @(negedge clk32);
    wr_addr = 5'h02;
    @(negedge clk32);
    wr_req = 1'b0; clr_req = 1'b1;
    @(negedge clk32);
    clr_req = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_ovf", ovf, 0);
    check("clr_full", wr_full, 0);
    repeat (40) @(negedge clk32);
    wr_req = 1'b1; wr_addr = 5'h11; wr_data = 8'h77; clr_req = 1'b1;
    push_wr(5'h11, 8'h77);
    @(negedge clk32);
    wr_req = 1'b0; clr_req = 1'b0;
    wait_idle(1200);

    // Reset in the middle of a write slot
    push_wr(5'h02, 8'h99);
    sync16();
    wr_req = 1'b1; wr_addr = 5'h02; wr_data = 8'h99;
    @(negedge clk32);
    wr_req = 1'b0;
    sync16();
    check("slot_live", sid_cs, 0);
    repeat (4) @(negedge clk32);
    rst_n = 1'b0;
    @(negedge clk32);
    check("abort_cs", sid_cs, 1);
    check("abort_wr", sid_wr, 1);
    check("abort_oe", sid_oe, 0);
    check("abort_busy", busy, 1);
    repeat (2) @(negedge clk32);
    push_clear();
    release_and_time(1'b1);
    wait_idle(200);
    check("sq_empty", sq.size(), 0);
    check("rq_empty", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
